// File: rtl/studio_keypad_pkg.sv
// Shared definitions for the keypad front end: size limits, the decoded
// key record and the scancode-to-key map.
package studio_keypad_pkg;

  localparam int MAX_PADS = 4;
  localparam int MAX_KEYS = 16;
  localparam int KEY_W    = 4;

  typedef struct packed {
    logic       hit;
    logic [1:0] pad;
    logic [3:0] idx;
  } keymap_t;

  // Pads 0/1 use plain scancodes; pads 2/3 reuse the same codes with the
  // E0 prefix, but only for the ten base keys.
  function automatic keymap_t keymap(input logic ext, input logic [7:0] code);
    keymap_t    r;
    logic       found;
    logic       pad_hi;
    logic [3:0] idx;
    found  = 1'b1;
    pad_hi = 1'b0;
    idx    = 4'd0;
    case (code)
      8'h45: idx = 4'd0;
      8'h16: idx = 4'd1;
      8'h1E: idx = 4'd2;
      8'h26: idx = 4'd3;
      8'h25: idx = 4'd4;
      8'h2E: idx = 4'd5;
      8'h36: idx = 4'd6;
      8'h3D: idx = 4'd7;
      8'h3E: idx = 4'd8;
      8'h46: idx = 4'd9;
      8'h1C: idx = 4'd10;
      8'h1B: idx = 4'd11;
      8'h23: idx = 4'd12;
      8'h2B: idx = 4'd13;
      8'h34: idx = 4'd14;
      8'h33: idx = 4'd15;
      8'h4D: begin pad_hi = 1'b1; idx = 4'd0;  end
      8'h15: begin pad_hi = 1'b1; idx = 4'd1;  end
      8'h1D: begin pad_hi = 1'b1; idx = 4'd2;  end
      8'h24: begin pad_hi = 1'b1; idx = 4'd3;  end
      8'h2D: begin pad_hi = 1'b1; idx = 4'd4;  end
      8'h2C: begin pad_hi = 1'b1; idx = 4'd5;  end
      8'h35: begin pad_hi = 1'b1; idx = 4'd6;  end
      8'h3C: begin pad_hi = 1'b1; idx = 4'd7;  end
      8'h43: begin pad_hi = 1'b1; idx = 4'd8;  end
      8'h44: begin pad_hi = 1'b1; idx = 4'd9;  end
      8'h1A: begin pad_hi = 1'b1; idx = 4'd10; end
      8'h22: begin pad_hi = 1'b1; idx = 4'd11; end
      8'h21: begin pad_hi = 1'b1; idx = 4'd12; end
      8'h2A: begin pad_hi = 1'b1; idx = 4'd13; end
      8'h32: begin pad_hi = 1'b1; idx = 4'd14; end
      8'h31: begin pad_hi = 1'b1; idx = 4'd15; end
      default: found = 1'b0;
    endcase
    if (ext && idx >= 4'd10) found = 1'b0;
    r.hit = found;
    r.pad = {ext, pad_hi};
    r.idx = idx;
    return r;
  endfunction

endpackage

// File: rtl/studio_keypad_mux_hold_cell.sv
// One key: raw pressed bit plus a release stretcher so short taps stay
// visible for HOLD_TICKS tick periods after the key is let go.
module keypad_hold_cell #(
  parameter int HOLD_TICKS = 4,
  parameter int HOLD_W     = 3
) (
  input  logic clk,
  input  logic srst,
  input  logic set_en,
  input  logic set_val,
  input  logic tick,
  output logic state
);

  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_TICKS);

  logic              raw_q, raw_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;

  // Next state; the counter looks at the old raw bit, so a release that
  // lands on a tick reloads the counter instead of consuming that tick.
  always_comb begin
    raw_d = set_en ? set_val : raw_q;
    cnt_d = cnt_q;
    if (raw_q) begin
      cnt_d = HOLD_LOAD;
    end else if (tick && cnt_q != '0) begin
      cnt_d = cnt_q - HOLD_W'(1);
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (srst) begin
      raw_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      raw_q <= raw_d;
      cnt_q <= cnt_d;
    end
  end

  assign state = raw_q | (cnt_q != '0);

endmodule

// File: rtl/studio_keypad_mux.sv
// Keypad front end: decodes ps2_key events into per-key state for up to
// four pads and drives one EF bit per pad from the CPU key-select latch.
module studio_keypad_mux
  import studio_keypad_pkg::*;
#(
  parameter int         NUM_PADS     = 2,
  parameter int         KEYS_PER_PAD = 10,
  parameter logic [2:0] LATCH_PORT   = 3'd1,
  parameter int         HOLD_TICKS   = 4,
  parameter int         HOLD_W       = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1
) (
  input  logic                             clk_sys,
  input  logic                             reset,
  input  logic [10:0]                      ps2_key,
  input  logic                             tick,
  input  logic                             io_out,
  input  logic [2:0]                       io_n,
  input  logic [7:0]                       cpu_dout,
  output logic [NUM_PADS-1:0]              ef_key,
  output logic [NUM_PADS*KEYS_PER_PAD-1:0] key_state,
  output logic                             any_key,
  output logic [3:0]                       key_sel
);

  logic                             old_toggle_q;
  logic                             ps2_event;
  keymap_t                          km;
  logic [KEY_W-1:0]                 key_sel_q, key_sel_d;
  logic [NUM_PADS-1:0]              ef_key_q, ef_key_d;
  logic                             any_key_q, any_key_d;
  logic [NUM_PADS*KEYS_PER_PAD-1:0] state_flat;
  logic                             cpu_dout_unused;

  assign cpu_dout_unused = ^cpu_dout[7:4];

  assign ps2_event = ps2_key[10] ^ old_toggle_q;
  assign km        = keymap(ps2_key[8], ps2_key[7:0]);

  // Cells exist only for in-range pads and keys, so events that decode to
  // a missing pad or index simply match no cell and are dropped.
  for (genvar gi = 0; gi < NUM_PADS; gi++) begin : g_pad
    for (genvar gk = 0; gk < KEYS_PER_PAD; gk++) begin : g_key
      localparam logic [1:0] PAD_ID = 2'(gi);
      localparam logic [3:0] KEY_ID = 4'(gk);
      logic set_en;
      assign set_en = ps2_event && km.hit && (km.pad == PAD_ID) && (km.idx == KEY_ID);
      keypad_hold_cell #(
        .HOLD_TICKS(HOLD_TICKS),
        .HOLD_W    (HOLD_W)
      ) u_cell (
        .clk    (clk_sys),
        .srst   (reset),
        .set_en (set_en),
        .set_val(ps2_key[9]),
        .tick   (tick),
        .state  (state_flat[gi*KEYS_PER_PAD + gk])
      );
    end

    // Pad the key row out to 16 entries so selects beyond KEYS_PER_PAD read 0.
    logic [MAX_KEYS-1:0] pad_vec;
    always_comb begin
      pad_vec                     = '0;
      pad_vec[KEYS_PER_PAD-1:0]   = state_flat[gi*KEYS_PER_PAD +: KEYS_PER_PAD];
    end
    assign ef_key_d[gi] = pad_vec[key_sel_q];
  end

  // Latch and summary next-state.
  always_comb begin
    key_sel_d = key_sel_q;
    if (io_out && io_n == LATCH_PORT) begin
      key_sel_d = cpu_dout[3:0];
    end
    any_key_d = |state_flat;
  end

  // Registers; the toggle tracker follows ps2_key even in reset so leaving
  // reset does not look like a new event.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      old_toggle_q <= ps2_key[10];
      key_sel_q    <= '0;
      ef_key_q     <= '0;
      any_key_q    <= 1'b0;
    end else begin
      old_toggle_q <= ps2_key[10];
      key_sel_q    <= key_sel_d;
      ef_key_q     <= ef_key_d;
      any_key_q    <= any_key_d;
    end
  end

  assign ef_key    = ef_key_q;
  assign key_state = state_flat;
  assign any_key   = any_key_q;
  assign key_sel   = key_sel_q;

endmodule

// File: tb/tb_studio_keypad_mux.sv
// Directed bench for studio_keypad_mux: three instances (default, no
// stretch, four pads x sixteen keys) driven from shared stimulus.
module tb_studio_keypad_mux;

  logic        clk_sys;
  logic        reset;
  logic [10:0] ps2_key;
  logic        tick;
  logic        io_out;
  logic [2:0]  io_n;
  logic [7:0]  cpu_dout;

  logic [1:0]  ef_a;   logic [19:0] ks_a;   logic any_a;   logic [3:0] sel_a;
  logic [1:0]  ef_z;   logic [19:0] ks_z;   logic any_z;   logic [3:0] sel_z;
  logic [3:0]  ef_f;   logic [63:0] ks_f;   logic any_f;   logic [3:0] sel_f;

  int errors = 0;
  int checks = 0;

  studio_keypad_mux #(.NUM_PADS(2), .KEYS_PER_PAD(10), .LATCH_PORT(3'd1), .HOLD_TICKS(4)) dut (
    .clk_sys(clk_sys), .reset(reset), .ps2_key(ps2_key), .tick(tick), .io_out(io_out),
    .io_n(io_n), .cpu_dout(cpu_dout), .ef_key(ef_a), .key_state(ks_a), .any_key(any_a),
    .key_sel(sel_a));

  studio_keypad_mux #(.NUM_PADS(2), .KEYS_PER_PAD(10), .LATCH_PORT(3'd1), .HOLD_TICKS(0)) dut0 (
    .clk_sys(clk_sys), .reset(reset), .ps2_key(ps2_key), .tick(tick), .io_out(io_out),
    .io_n(io_n), .cpu_dout(cpu_dout), .ef_key(ef_z), .key_state(ks_z), .any_key(any_z),
    .key_sel(sel_z));

  studio_keypad_mux #(.NUM_PADS(4), .KEYS_PER_PAD(16), .LATCH_PORT(3'd1), .HOLD_TICKS(4)) dut4 (
    .clk_sys(clk_sys), .reset(reset), .ps2_key(ps2_key), .tick(tick), .io_out(io_out),
    .io_n(io_n), .cpu_dout(cpu_dout), .ef_key(ef_f), .key_state(ks_f), .any_key(any_f),
    .key_sel(sel_f));

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic ps2(input logic ext, input logic pr, input logic [7:0] code);
    ps2_key = {~ps2_key[10], pr, ext, code};
    $display("ps2 ext=%0b pressed=%0b code=%h", ext, pr, code);
    cyc(1);
  endtask

  task automatic latch(input logic [2:0] port, input logic [7:0] d);
    io_out = 1'b1; io_n = port; cpu_dout = d;
    $display("out port=%0d data=%h", port, d);
    cyc(1);
    io_out = 1'b0;
  endtask

  task automatic pulse_tick();
    tick = 1'b1; cyc(1); tick = 1'b0; cyc(1);
  endtask

  task automatic test_reset();
    reset = 1'b1; tick = 1'b0; io_out = 1'b0; io_n = 3'd0; cpu_dout = 8'h00;
    ps2_key = {1'b1, 1'b1, 1'b0, 8'h45};
    cyc(3);
    reset = 1'b0;
    cyc(3);
    checks++; if (ef_a !== 2'b00) begin errors++; $display("FAIL reset_ef: got %b want 00", ef_a); end
    checks++; if (any_a !== 1'b0) begin errors++; $display("FAIL reset_any: got %b want 0", any_a); end
    checks++; if (sel_a !== 4'd0) begin errors++; $display("FAIL reset_sel: got %0d want 0", sel_a); end
    checks++; if (ks_a !== 20'h0) begin errors++; $display("FAIL reset_no_event: got %h want 00000", ks_a); end
    checks++; if (ks_f !== 64'h0) begin errors++; $display("FAIL reset_no_event4: got %h want 0", ks_f); end
  endtask

  task automatic test_basic();
    latch(3'd1, 8'h03);
    checks++; if (sel_z !== 4'd3) begin errors++; $display("FAIL latch_load: got %0d want 3", sel_z); end
    latch(3'd2, 8'h05);
    checks++; if (sel_z !== 4'd3) begin errors++; $display("FAIL latch_wrong_port: got %0d want 3", sel_z); end
    ps2(1'b0, 1'b1, 8'h26);
    checks++; if (ef_z !== 2'b00) begin errors++; $display("FAIL make_latency: got %b want 00", ef_z); end
    cyc(1);
    checks++; if (ef_z !== 2'b01) begin errors++; $display("FAIL make_ef: got %b want 01", ef_z); end
    ps2(1'b0, 1'b0, 8'h26);
    cyc(1);
    checks++; if (ef_z !== 2'b00) begin errors++; $display("FAIL break_nohold: got %b want 00", ef_z); end
    checks++; if (ef_a !== 2'b01) begin errors++; $display("FAIL break_held: got %b want 01", ef_a); end
  endtask

  task automatic test_hold_stretch();
    latch(3'd1, 8'h01);
    ps2(1'b0, 1'b1, 8'h15);
    cyc(1);
    checks++; if (ef_a !== 2'b10) begin errors++; $display("FAIL hold_press: got %b want 10", ef_a); end
    tick = 1'b1;
    ps2(1'b0, 1'b0, 8'h15);
    tick = 1'b0;
    cyc(1);
    checks++; if (ef_a !== 2'b10) begin errors++; $display("FAIL hold_release: got %b want 10", ef_a); end
    checks++; if (ef_z !== 2'b00) begin errors++; $display("FAIL nohold_release: got %b want 00", ef_z); end
    for (int t = 1; t <= 4; t++) begin
      pulse_tick();
      checks++;
      if (ef_a[1] !== (t < 4)) begin
        errors++; $display("FAIL hold_tick%0d: got %b want %b", t, ef_a[1], (t < 4));
      end
    end
  endtask

  task automatic test_range_map();
    latch(3'd1, 8'h00);
    ps2(1'b0, 1'b1, 8'h45);
    cyc(1);
    checks++; if (ef_a !== 2'b01) begin errors++; $display("FAIL sel0_ef: got %b want 01", ef_a); end
    latch(3'd1, 8'h0C);
    cyc(1);
    checks++; if (ef_a !== 2'b00) begin errors++; $display("FAIL sel_out_of_range: got %b want 00", ef_a); end
    checks++; if (any_a !== 1'b1) begin errors++; $display("FAIL any_key_set: got %b want 1", any_a); end
    ps2(1'b1, 1'b1, 8'h45);
    cyc(1);
    checks++; if (ks_a !== 20'h00001) begin errors++; $display("FAIL ext_pad_absent: got %h want 00001", ks_a); end
    ps2(1'b0, 1'b1, 8'h23);
    cyc(1);
    checks++; if (ks_a !== 20'h00001) begin errors++; $display("FAIL idx_out_of_range: got %h want 00001", ks_a); end
  endtask

  task automatic test_four_pads();
    ps2(1'b1, 1'b1, 8'h1E);
    latch(3'd1, 8'h02);
    cyc(1);
    checks++; if (ef_f !== 4'b0100) begin errors++; $display("FAIL four_sel2: got %b want 0100", ef_f); end
    latch(3'd1, 8'h0C);
    cyc(1);
    checks++; if (ef_f !== 4'b0001) begin errors++; $display("FAIL four_sel12: got %b want 0001", ef_f); end
    checks++; if (any_f !== 1'b1) begin errors++; $display("FAIL four_any: got %b want 1", any_f); end
    checks++; if (ks_f !== 64'h0000_0005_0000_1001) begin
      errors++; $display("FAIL four_state: got %h want 0000000500001001", ks_f);
    end
  endtask

  task automatic test_back_to_back();
    io_out = 1'b1; io_n = 3'd1; cpu_dout = 8'h01;
    ps2(1'b0, 1'b1, 8'h16);
    io_out = 1'b0;
    cyc(1);
    checks++; if (ef_z !== 2'b01) begin errors++; $display("FAIL simul_ef: got %b want 01", ef_z); end
    checks++; if (sel_z !== 4'd1) begin errors++; $display("FAIL simul_sel: got %0d want 1", sel_z); end
    ps2(1'b0, 1'b0, 8'h16);
    ps2(1'b0, 1'b1, 8'h16);
    checks++; if (ks_z !== 20'h00003) begin errors++; $display("FAIL b2b_make_wins: got %h want 00003", ks_z); end
    ps2(1'b0, 1'b1, 8'h16);
    ps2(1'b0, 1'b0, 8'h16);
    checks++; if (ks_z !== 20'h00001) begin errors++; $display("FAIL b2b_break_wins: got %h want 00001", ks_z); end
  endtask

  task automatic test_mid_hold_reset();
    latch(3'd1, 8'h00);
    ps2(1'b0, 1'b0, 8'h45);
    pulse_tick();
    pulse_tick();
    checks++; if (ks_a !== 20'h00003) begin errors++; $display("FAIL midhold_state: got %h want 00003", ks_a); end
    checks++; if (ef_a !== 2'b01) begin errors++; $display("FAIL midhold_ef: got %b want 01", ef_a); end
    reset = 1'b1;
    cyc(1);
    checks++; if (ks_a !== 20'h0) begin errors++; $display("FAIL midreset_state: got %h want 00000", ks_a); end
    checks++; if (ef_a !== 2'b00) begin errors++; $display("FAIL midreset_ef: got %b want 00", ef_a); end
    checks++; if (ks_f !== 64'h0) begin errors++; $display("FAIL midreset_state4: got %h want 0", ks_f); end
    checks++; if (sel_a !== 4'd0) begin errors++; $display("FAIL midreset_sel: got %0d want 0", sel_a); end
    reset = 1'b0;
    cyc(2);
    checks++; if (ks_a !== 20'h0) begin errors++; $display("FAIL postreset_state: got %h want 00000", ks_a); end
    checks++; if (any_a !== 1'b0) begin errors++; $display("FAIL postreset_any: got %b want 0", any_a); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold_stretch();
    test_range_map();
    test_four_pads();
    test_back_to_back();
    test_mid_hold_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
